// File: rtl/dcs_host.sv
// dcs_host: streams a 128-byte input matrix and 8 weight bytes to an
// accelerator, then collects 8 result beats with a per-phase timeout.
module dcs_host (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        start,
  input  logic        w_ready,
  input  logic        o_valid,
  input  logic [31:0] o_data,
  output logic        i_valid,
  output logic [7:0]  i_data,
  output logic        w_valid,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [2:0]  res_addr,
  output logic [31:0] res_data
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_I   = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_SEND_W   = 3'd3,
    ST_COLLECT  = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } state_t;

  state_t      r_state;
  logic [7:0]  r_ibuf [0:127];
  logic [7:0]  r_wbuf [0:7];
  logic [31:0] r_res  [0:7];
  logic [6:0]  r_cnt;
  logic [2:0]  r_wcnt;
  logic [2:0]  r_n;
  logic [7:0]  r_timer;
  logic        r_wrdy_q;
  logic        r_i_valid;
  logic [7:0]  r_i_data;
  logic        r_w_valid;
  logic [7:0]  r_w_data;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_open;
  logic        w_cfg_ok;
  logic        w_ibuf_wr;
  logic        w_wbuf_wr;
  logic [7:0]  w_first_i;
  logic        w_wrdy_rise;
  logic        w_timeout;
  logic        w_capture;
  logic [6:0]  w_cnt_nxt;
  logic [2:0]  w_wcnt_nxt;

  // The block only accepts configuration and start while not running.
  assign w_open      = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_cfg_ok    = cfg_we && w_open;
  assign w_ibuf_wr   = w_cfg_ok && (cfg_addr[7] == 1'b0);
  assign w_wbuf_wr   = w_cfg_ok && (cfg_addr[7:3] == 5'b10000);
  // A write to byte 0 in the start cycle must be the first byte streamed.
  assign w_first_i   = (w_ibuf_wr && (cfg_addr[6:0] == 7'd0)) ? cfg_data : r_ibuf[0];
  assign w_wrdy_rise = w_ready && !r_wrdy_q;
  // Timer value 254 on a cycle means this is the 255th idle cycle.
  assign w_timeout   = (r_timer == 8'd254);
  assign w_capture   = (r_state == ST_COLLECT) && o_valid;
  assign w_cnt_nxt   = r_cnt + 7'd1;
  assign w_wcnt_nxt  = r_wcnt + 3'd1;

  assign i_valid  = r_i_valid;
  assign i_data   = r_i_data;
  assign w_valid  = r_w_valid;
  assign w_data   = r_w_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign res_data = r_res[res_addr];

  // Input-matrix and weight buffers, written only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 128; k++) r_ibuf[k] <= 8'd0;
      for (int j = 0; j < 8; j++) r_wbuf[j] <= 8'd0;
    end else begin
      if (w_ibuf_wr) r_ibuf[cfg_addr[6:0]] <= cfg_data;
      if (w_wbuf_wr) r_wbuf[cfg_addr[2:0]] <= cfg_data;
    end
  end

  // Result capture; contents survive start and timeouts, only reset clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 8; n++) r_res[n] <= 32'd0;
    end else begin
      if (w_capture) r_res[r_n] <= o_data;
    end
  end

  // Run sequencer with registered stream and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 7'd0;
      r_wcnt    <= 3'd0;
      r_n       <= 3'd0;
      r_timer   <= 8'd0;
      r_wrdy_q  <= 1'b0;
      r_i_valid <= 1'b0;
      r_i_data  <= 8'd0;
      r_w_valid <= 1'b0;
      r_w_data  <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wrdy_q <= w_ready;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state   <= ST_SEND_I;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_cnt     <= 7'd0;
            r_wcnt    <= 3'd0;
            r_n       <= 3'd0;
            r_timer   <= 8'd0;
            r_i_valid <= 1'b1;
            r_i_data  <= w_first_i;
          end
        end
        ST_SEND_I: begin
          if (r_cnt == 7'd127) begin
            r_state   <= ST_WAIT_RDY;
            r_i_valid <= 1'b0;
            r_i_data  <= 8'd0;
            r_timer   <= 8'd0;
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_i_data <= r_ibuf[w_cnt_nxt];
          end
        end
        ST_WAIT_RDY: begin
          if (w_wrdy_rise) begin
            r_state   <= ST_SEND_W;
            r_w_valid <= 1'b1;
            r_w_data  <= r_wbuf[0];
            r_wcnt    <= 3'd0;
            r_timer   <= 8'd0;
          end else if (w_timeout) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_timer <= 8'd0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        ST_SEND_W: begin
          if (r_wcnt == 3'd7) begin
            r_state   <= ST_COLLECT;
            r_w_valid <= 1'b0;
            r_w_data  <= 8'd0;
            r_timer   <= 8'd0;
          end else begin
            r_wcnt   <= w_wcnt_nxt;
            r_w_data <= r_wbuf[w_wcnt_nxt];
          end
        end
        ST_COLLECT: begin
          if (o_valid) begin
            r_n     <= r_n + 3'd1;
            r_timer <= 8'd0;
            if (r_n == 3'd7) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_timer <= 8'd0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_i_valid <= 1'b0;
          r_i_data  <= 8'd0;
          r_w_valid <= 1'b0;
          r_w_data  <= 8'd0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dcs_host.md
DCS_HOST -- requirements
Module: dcs_host

Interface
REQ-001 Clock/reset SHALL be one clock and an asynchronous active-low reset: clk (rising edge) and rst_n (active-low, asynchronous assert).
REQ-002 Ports SHALL be, one per line, name  direction  width  meaning:
  clk  in  1  system clock
  rst_n  in  1  async active-low reset
  cfg_we  in  1  buffer write strobe
  cfg_addr  in  8  0-127 input-matrix byte k, 128-135 weight byte (addr-128)
  cfg_data  in  8  byte to write
  start  in  1  one-cycle run request
  w_ready  in  1  accelerator ready-for-weights pulse
  o_valid  in  1  accelerator result beat valid
  o_data  in  32  accelerator result beat
  i_valid  out  1  input-matrix byte valid
  i_data  out  8  input-matrix byte
  w_valid  out  1  weight byte valid
  w_data  out  8  weight byte
  busy  out  1  run in progress
  done  out  1  8 results captured
  err  out  1  timeout occurred
  res_addr  in  3  result read index
  res_data  out  32  captured result[res_addr], combinational read

Function
REQ-003 Buffers SHALL be ibuf[0:127] and wbuf[0:7] (8-bit) and res[0:7] (32-bit).
REQ-004 cfg_we SHALL write on the clock edge only in IDLE/DONE/ERR; cfg_addr >= 136 is ignored, and cfg_we is ignored while busy.
REQ-005 The FSM SHALL have states IDLE, SEND_I, WAIT_RDY, SEND_W, COLLECT, DONE, ERR; busy=1 exactly in SEND_I..COLLECT.
REQ-006 start sampled in IDLE/DONE/ERR SHALL move to SEND_I next cycle, clear done and err, reset the beat counter and timer, and leave res untouched; start is ignored while busy.
REQ-007 SEND_I SHALL run exactly 128 consecutive cycles with i_valid=1 and i_data=ibuf[k] on cycle k (k=0..127), with no gaps, then go to WAIT_RDY.
REQ-008 WAIT_RDY SHALL have a rising w_ready sample go to SEND_W next cycle; w_ready seen in any other state is ignored.
REQ-009 SEND_W SHALL run exactly 8 consecutive cycles with w_valid=1 and w_data=wbuf[j] (j=0..7), then go to COLLECT.
REQ-010 COLLECT SHALL capture each cycle with o_valid=1 as res[n]<=o_data, n++ (3-bit); after the 8th capture it enters DONE; gaps between beats are allowed.
REQ-011 o_valid outside COLLECT SHALL be ignored (no capture, no error).
REQ-012 Timeout: an 8-bit timer counts cycles spent in WAIT_RDY, and separately in COLLECT since the last beat; reaching 255 enters ERR (err=1, busy=0). Partial res content is retained.
REQ-013 done and err SHALL be levels held until the next accepted start or reset; done and err are never both 1.
REQ-014 Whenever i_valid=0 then i_data SHALL be 0, and whenever w_valid=0 then w_data SHALL be 0; i_valid and w_valid are never both 1.
REQ-015 If start and cfg_we occur in the same IDLE cycle, the write SHALL complete first and the run uses the new byte.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE; i_valid, w_valid, busy, done, err = 0; i_data, w_data = 0; counters and timer = 0; ibuf, wbuf, res = 0.
REQ-017 A reset mid-run SHALL abort immediately with no further i_valid/w_valid beats; after release the block waits in IDLE for start.

Verification
REQ-018 ibuf[k]=k, wbuf[j]=0x10+j, start -> i_valid high cycles 1..128 with i_data 0x00..0x7F, then idle until w_ready.
REQ-019 w_ready pulse 5 cycles after SEND_I ends -> w_valid 8 cycles with w_data 0x10..0x17, then COLLECT.
REQ-020 8 o_valid beats 0x1000_0000+n with 2-cycle gaps -> done=1, busy=0, res_addr=n reads 0x1000_0000+n.
REQ-021 No w_ready for 255 cycles in WAIT_RDY -> err=1, done=0, busy=0; a following start clears err and reruns.
REQ-022 rst_n low at SEND_I cycle 60 -> i_valid=0 the same cycle, all outputs 0, res_data=0 for all addresses.
REQ-023 Stray o_valid in WAIT_RDY, plus cfg_we/start while busy -> no capture, buffers unchanged, run completes normally.
